// File: rtl/ram_prog_nxw_pkg.sv
// Shared definitions for the ram_prog_nxw program/run memory:
// FSM state encodings plus the mode and access-direction constants.
package ram_prog_nxw_pkg;

    // Controller states; S_CLEAR is only reachable when RAM_CLEAR_EN is defined.
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PROG  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    // run_or_prog encodings
    localparam logic RUN   = 1'b1;
    localparam logic PROG  = 1'b0;

    // read_or_write encodings
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Map the sampled mode pin to the state it selects.
    function automatic state_t mode_state(input logic run_or_prog);
        state_t st;
        if (run_or_prog == RUN) begin
            st = S_RUN;
        end else begin
            st = S_PROG;
        end
        return st;
    endfunction

endpackage

// File: rtl/ram_addr_counter.sv
// Address counter with synchronous clear, parallel load and
// increment-with-wrap. Load and increment together yield load_value+1,
// which is what a "preset and write" programming cycle needs.
module ram_addr_counter #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] count
);

    logic [ADDR_WIDTH-1:0] count_r;
    logic [ADDR_WIDTH-1:0] base_s;
    logic [ADDR_WIDTH-1:0] next_s;

    // Select the load or hold value, then optionally step it (carry discarded).
    always_comb begin
        base_s = count_r;
        next_s = count_r;
        if (load) begin
            base_s = load_value;
        end else begin
            base_s = count_r;
        end
        if (inc) begin
            next_s = base_s + ADDR_WIDTH'(1);
        end else begin
            next_s = base_s;
        end
    end

    // Counter register; clear wins over load and increment.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            count_r <= next_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/ram_prog_nxw.sv
// Parametrised synchronous program/run memory.
// Program mode loads words through an auto-incrementing address counter;
// run mode gives registered reads (1-cycle latency) and direct writes.
// Optional feature macro: RAM_CLEAR_EN -- CLR sweeps zeros through the whole
// array (busy high for 2^ADDR_WIDTH cycles) before accepting requests.
module ram_prog_nxw
    import ram_prog_nxw_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  run_or_prog,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  CE_bar,
    input  logic                  read_or_write,
    input  logic [DATA_WIDTH-1:0] bus_data,
    input  logic [DATA_WIDTH-1:0] programmer_data,
    input  logic                  prog_load,
    input  logic                  prog_strobe,
    output logic [DATA_WIDTH-1:0] memory_value,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] prog_address,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                state_r;
    state_t                next_state_s;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] memory_value_r;
    logic                  mem_valid_r;
    logic                  we_s;
    logic [ADDR_WIDTH-1:0] waddr_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic                  rd_s;
    logic                  prog_load_s;
    logic                  prog_inc_s;
    logic [ADDR_WIDTH-1:0] prog_addr_s;
    logic [ADDR_WIDTH-1:0] sweep_addr_s;

    // Programming address: only moves while in program mode, kept across mode switches.
    assign prog_load_s = (state_r == S_PROG) && prog_load;
    assign prog_inc_s  = (state_r == S_PROG) && prog_strobe;

    ram_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_prog_cnt (
        .clk        (CLK),
        .clr        (CLR),
        .load       (prog_load_s),
        .load_value (address),
        .inc        (prog_inc_s),
        .count      (prog_addr_s)
    );

`ifdef RAM_CLEAR_EN
    logic busy_r;

    ram_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_sweep_cnt (
        .clk        (CLK),
        .clr        (CLR),
        .load       (1'b0),
        .load_value ({ADDR_WIDTH{1'b0}}),
        .inc        (state_r == S_CLEAR),
        .count      (sweep_addr_s)
    );

    // Next state: CLR forces a sweep; the sweep ends after writing the last word.
    always_comb begin
        next_state_s = mode_state(run_or_prog);
        if (CLR) begin
            next_state_s = S_CLEAR;
        end else if ((state_r == S_CLEAR) && (sweep_addr_s != {ADDR_WIDTH{1'b1}})) begin
            next_state_s = S_CLEAR;
        end else begin
            next_state_s = mode_state(run_or_prog);
        end
    end

    // busy is registered so it is high exactly while the controller sits in S_CLEAR.
    always_ff @(posedge CLK) begin
        busy_r <= (next_state_s == S_CLEAR);
    end

    assign busy = busy_r;
`else
    assign sweep_addr_s = {ADDR_WIDTH{1'b0}};

    // Next state simply follows the mode pin sampled at each edge.
    always_comb begin
        next_state_s = mode_state(run_or_prog);
    end

    assign busy = 1'b0;
`endif

    // State register; the reset behaviour is folded into next_state_s.
    always_ff @(posedge CLK) begin
        state_r <= next_state_s;
    end

    // Decode the single write port and the read request for the current state.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = address;
        wdata_s = bus_data;
        rd_s    = 1'b0;
        if (CLR) begin
            we_s = 1'b0;
            rd_s = 1'b0;
        end else begin
            case (state_r)
                S_RUN: begin
                    if (!CE_bar) begin
                        if (read_or_write == WRITE) begin
                            we_s = 1'b1;
                        end else begin
                            rd_s = 1'b1;
                        end
                    end else begin
                        we_s = 1'b0;
                    end
                end
                S_PROG: begin
                    wdata_s = programmer_data;
                    if (prog_strobe) begin
                        we_s = 1'b1;
                        if (prog_load) begin
                            waddr_s = address;
                        end else begin
                            waddr_s = prog_addr_s;
                        end
                    end else begin
                        we_s = 1'b0;
                    end
                end
                S_CLEAR: begin
                    we_s    = 1'b1;
                    waddr_s = sweep_addr_s;
                    wdata_s = {DATA_WIDTH{1'b0}};
                end
                default: begin
                    we_s = 1'b0;
                    rd_s = 1'b0;
                end
            endcase
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Registered read port: data holds unless a read completes this cycle.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            memory_value_r <= {DATA_WIDTH{1'b0}};
            mem_valid_r    <= 1'b0;
        end else if (rd_s) begin
            memory_value_r <= mem_r[address];
            mem_valid_r    <= 1'b1;
        end else begin
            mem_valid_r    <= 1'b0;
        end
    end

    assign memory_value = memory_value_r;
    assign mem_valid    = mem_valid_r;
    assign prog_address = prog_addr_s;

endmodule
